seq_divider_32: RTL and testbench

SEQ_DIVIDER_32 -- requirements
Module: seq_divider_32

---
 rtl/seq_divider_32_pkg.sv | 17 +
 rtl/thirtytwobitlookaheadadder.sv | 34 +++
 rtl/seq_divider_32.sv | 126 ++++++++++++
 tb/tb_seq_divider_32.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_32_pkg.sv
// rtl/seq_divider_32_pkg.sv - shared constants and FSM state type for the sequential divider
package seq_divider_32_pkg;

  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 32;
  localparam int CNT_W      = 5;

  localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0] LAST_ITER    = CNT_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/thirtytwobitlookaheadadder.sv
// rtl/thirtytwobitlookaheadadder.sv - 32-bit adder, 4-bit carry-lookahead groups rippled between groups
module thirtytwobitlookaheadadder (
  output logic [31:0] S,
  output logic        cout,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cin
);

  always_comb begin
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    g    = A & B;
    p    = A ^ B;
    c    = '0;
    c[0] = cin;
    for (int grp = 0; grp < 8; grp++) begin
      c[grp*4+1] = g[grp*4] | (p[grp*4] & c[grp*4]);
      c[grp*4+2] = g[grp*4+1] | (p[grp*4+1] & g[grp*4])
                 | (p[grp*4+1] & p[grp*4] & c[grp*4]);
      c[grp*4+3] = g[grp*4+2] | (p[grp*4+2] & g[grp*4+1])
                 | (p[grp*4+2] & p[grp*4+1] & g[grp*4])
                 | (p[grp*4+2] & p[grp*4+1] & p[grp*4] & c[grp*4]);
      c[grp*4+4] = g[grp*4+3] | (p[grp*4+3] & g[grp*4+2])
                 | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
                 | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4])
                 | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & p[grp*4] & c[grp*4]);
    end
    S    = p ^ c[31:0];
    cout = c[32];
  end

endmodule

// File: rtl/seq_divider_32.sv
// rtl/seq_divider_32.sv - 32-bit unsigned restoring divider, one quotient bit per clock
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  import seq_divider_32_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             commit;
  logic [WIDTH-1:0] rem_next;

  // Dividend register doubles as the quotient accumulator: bits shift out the top, quotient bits in the bottom.
  assign trial = {rem_q, dvd_q[WIDTH-1]};

  thirtytwobitlookaheadadder u_sub (
    .S    (diff),
    .cout (carry),
    .A    (trial[WIDTH-1:0]),
    .B    (~dvs_q),
    .cin  (1'b1)
  );

  assign commit   = trial[WIDTH] | carry;
  assign rem_next = commit ? diff : trial[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          rem_d = '0;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d     = FIN;
            quotient_d  = DBZ_QUOTIENT;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dvd_d = {dvd_q[WIDTH-2:0], commit};
        rem_d = rem_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d     = FIN;
          quotient_d  = {dvd_q[WIDTH-2:0], commit};
          remainder_d = rem_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// tb/tb_seq_divider_32.sv - directed and random scoreboard bench for seq_divider_32
module tb_seq_divider_32;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic [31:0] lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int          checks = 0;
  int          passed = 0;
  exp_t        sb[$];
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  seq_divider_32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at posedge+1; start is presented across exactly one rising edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input bit push, input string tag);
    exp_t e;
    if (push) begin
      if (b == 32'd0) begin
        e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.lat = 32'd1;
      end else begin
        e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = 32'd33;
      end
      sb.push_back(e);
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push && b != 32'd0) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_dbz_clr"}, 32'(div_by_zero), 32'd0);
    end
  endtask

  task automatic await_result(input string tag, input int start_edges);
    int   edges = start_edges;
    bit   held  = 1'b1;
    exp_t e;
    while (done !== 1'b1 && edges < 40) begin
      if (quotient !== last_q || remainder !== last_r) held = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_hidden"}, 32'(held), 32'd1);
    check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(edges), e.lat);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_fin"}, 32'(busy), 32'd0);
      check({tag, "_q"}, quotient, e.q);
      check({tag, "_r"}, remainder, e.r);
      check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
      last_q = e.q;
      last_r = e.r;
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          done_seen;

    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    accept(32'd100, 32'd7, 1'b1, "d100_7");
    await_result("d100_7", 1);
    @(posedge clk); #1;
    check("fin_idle_done", 32'(done), 32'd0);
    check("fin_idle_busy", 32'(busy), 32'd0);
    check("fin_idle_q_held", quotient, 32'd14);
    check("fin_idle_r_held", remainder, 32'd2);

    accept(32'h8000_0000, 32'h8000_0000, 1'b1, "msb_msb");
    await_result("msb_msb", 1);
    accept(32'hFFFF_FFFF, 32'd1, 1'b1, "max_1");
    await_result("max_1", 1);

    accept(32'd5, 32'd0, 1'b1, "dbz_5_0");
    await_result("dbz_5_0", 1);
    @(posedge clk); #1;
    check("dbz_held", 32'(div_by_zero), 32'd1);
    check("dbz_r_held", remainder, 32'd5);

    accept(32'd3, 32'd10, 1'b1, "d3_10");
    await_result("d3_10", 1);
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, "trial33");
    await_result("trial33", 1);

    accept(32'd50, 32'd3, 1'b1, "d50_3");
    repeat (9) begin
      @(posedge clk); #1;
    end
    dividend = 32'd9;
    divisor  = 32'd9;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_start_busy", 32'(busy), 32'd1);
    await_result("d50_3", 11);
    accept(32'd9, 32'd4, 1'b1, "b2b_9_4");
    await_result("b2b_9_4", 1);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      accept(ra, rb, 1'b1, "rand");
      await_result("rand", 1);
    end

    accept(32'd100, 32'd7, 1'b0, "rst_run");
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    last_q    = '0;
    last_r    = '0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);

    accept(32'd100, 32'd7, 1'b1, "post_rst");
    await_result("post_rst", 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
